rv32i_wb_top: RTL and testbench

- Writeback stage of the RV32I pipeline. It sits directly downstream of the memory stage and consumes that stage's registered outputs: pc, iw, alu result, wb_reg and wb_en.
- Owns the 32x32 architectural register file: one synchronous write port and two combinational read ports with write-through bypass for the decode stage.
- Exports writeback-stage forwarding signals.
- Maintains 64-bit cycle and retired-instruction counters, plus the PC of the last retired instruction.

---
 rtl/rv32i_wb_top.sv | 90 +++++++++
 tb/tb_rv32i_wb_top.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_wb_top.sv
// RV32I writeback stage: register file (2R/1W, write-through bypass), forwarding, cycle/retire counters.
// Latency: reads and forwarding are combinational; writes and counters are visible one cycle later.
// Backpressure: none; every cycle is consumed unconditionally, with no stall or flush.
module rv32i_wb_top #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb_en_in,
  input  logic [XLEN-1:0]  pc_in,
  input  logic [XLEN-1:0]  iw_in,
  input  logic [XLEN-1:0]  alu_in,
  input  logic [4:0]       wb_reg_in,
  input  logic [4:0]       rs1_reg,
  input  logic [4:0]       rs2_reg,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  output logic             df_wb_enable,
  output logic [4:0]       df_wb_reg,
  output logic [XLEN-1:0]  df_wb_data,
  output logic [CNT_W-1:0] retired_count,
  output logic [CNT_W-1:0] cycle_count,
  output logic [XLEN-1:0]  pc_last
);

  logic [XLEN-1:0] regs [32];
  logic            we;
  logic            ret;
  logic            unused_iw_hi;

  // Reset suppresses both the write and the retire of whatever is presented that cycle.
  assign we  = reset && wb_en_in && (wb_reg_in != 5'd0);
  assign ret = reset && (iw_in[1:0] == 2'b11);

  // Only the encoding-length bits matter for retirement.
  assign unused_iw_hi = ^iw_in[XLEN-1:2];

  // Forwarding mirrors the write port; disabled for x0 and during reset.
  assign df_wb_enable = we;
  assign df_wb_reg    = wb_reg_in;
  assign df_wb_data   = alu_in;

  // Read port 1: x0 is hardwired zero, then the in-flight write, then the array.
  always_comb begin
    rs1_data = regs[rs1_reg];
    if (rs1_reg == 5'd0) begin
      rs1_data = '0;
    end else if (we && (rs1_reg == wb_reg_in)) begin
      rs1_data = alu_in;
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    rs2_data = regs[rs2_reg];
    if (rs2_reg == 5'd0) begin
      rs2_data = '0;
    end else if (we && (rs2_reg == wb_reg_in)) begin
      rs2_data = alu_in;
    end
  end

  // Register array: synchronous clear on reset, single write port otherwise.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[wb_reg_in] <= alu_in;
    end
  end

  // Performance counters and last-retired PC; counters wrap silently.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_count   <= '0;
      retired_count <= '0;
      pc_last       <= '0;
    end else begin
      cycle_count <= cycle_count + 1'b1;
      if (ret) begin
        retired_count <= retired_count + 1'b1;
        pc_last       <= pc_in;
      end
    end
  end

endmodule

// File: tb/tb_rv32i_wb_top.sv
module tb_rv32i_wb_top;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        wb_en_in;
  logic [31:0] pc_in;
  logic [31:0] iw_in;
  logic [31:0] alu_in;
  logic [4:0]  wb_reg_in;
  logic [4:0]  rs1_reg;
  logic [4:0]  rs2_reg;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        df_wb_enable;
  logic [4:0]  df_wb_reg;
  logic [31:0] df_wb_data;
  logic [63:0] retired_count;
  logic [63:0] cycle_count;
  logic [31:0] pc_last;

  // narrow-counter instance, so counter wrap is reachable in a short run
  logic [31:0] s_rs1_data;
  logic [31:0] s_rs2_data;
  logic        s_df_wb_enable;
  logic [4:0]  s_df_wb_reg;
  logic [31:0] s_df_wb_data;
  logic [2:0]  s_retired_count;
  logic [2:0]  s_cycle_count;
  logic [31:0] s_pc_last;

  rv32i_wb_top dut (
    .clk           (clk),
    .reset         (reset),
    .wb_en_in      (wb_en_in),
    .pc_in         (pc_in),
    .iw_in         (iw_in),
    .alu_in        (alu_in),
    .wb_reg_in     (wb_reg_in),
    .rs1_reg       (rs1_reg),
    .rs2_reg       (rs2_reg),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .df_wb_enable  (df_wb_enable),
    .df_wb_reg     (df_wb_reg),
    .df_wb_data    (df_wb_data),
    .retired_count (retired_count),
    .cycle_count   (cycle_count),
    .pc_last       (pc_last)
  );

  rv32i_wb_top #(.XLEN(32), .CNT_W(3)) dut_s (
    .clk           (clk),
    .reset         (reset),
    .wb_en_in      (wb_en_in),
    .pc_in         (pc_in),
    .iw_in         (iw_in),
    .alu_in        (alu_in),
    .wb_reg_in     (wb_reg_in),
    .rs1_reg       (rs1_reg),
    .rs2_reg       (rs2_reg),
    .rs1_data      (s_rs1_data),
    .rs2_data      (s_rs2_data),
    .df_wb_enable  (s_df_wb_enable),
    .df_wb_reg     (s_df_wb_reg),
    .df_wb_data    (s_df_wb_data),
    .retired_count (s_retired_count),
    .cycle_count   (s_cycle_count),
    .pc_last       (s_pc_last)
  );

  typedef struct {
    logic [31:0] r1;
    logic [31:0] r2;
    logic        den;
    logic [4:0]  dreg;
    logic [31:0] ddat;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;

  // reference model state
  logic [31:0] m_regs [32];
  logic [63:0] m_cyc;
  logic [63:0] m_ret;
  logic [31:0] m_pc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a, input logic mwe,
                                         input logic [4:0] wreg, input logic [31:0] alu);
    if (a == 5'd0) return 32'h0;
    if (mwe && (a == wreg)) return alu;
    return m_regs[a];
  endfunction

  // One clock: drive, score combinational outputs, clock, score registered outputs.
  task automatic cyc(input logic rst, input logic en, input logic [4:0] wreg,
                     input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] iw,
                     input logic [4:0] r1, input logic [4:0] r2, input bit chk);
    exp_t e;
    logic mwe;
    reset = rst; wb_en_in = en; wb_reg_in = wreg; alu_in = alu;
    pc_in = pc; iw_in = iw; rs1_reg = r1; rs2_reg = r2;
    mwe    = rst && en && (wreg != 5'd0);
    e.r1   = m_read(r1, mwe, wreg, alu);
    e.r2   = m_read(r2, mwe, wreg, alu);
    e.den  = mwe;
    e.dreg = wreg;
    e.ddat = alu;
    sb.push_back(e);
    #2;
    e = sb.pop_front();
    if (chk) begin
      check("rs1_data", rs1_data, e.r1);
      check("rs2_data", rs2_data, e.r2);
      check("df_wb_enable", df_wb_enable, e.den);
      check("df_wb_reg", df_wb_reg, e.dreg);
      check("df_wb_data", df_wb_data, e.ddat);
    end
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_cyc = 64'h0;
      m_ret = 64'h0;
      m_pc  = 32'h0;
    end else begin
      if (mwe) m_regs[wreg] = alu;
      m_cyc = m_cyc + 64'h1;
      if (iw[1:0] == 2'b11) begin
        m_ret = m_ret + 64'h1;
        m_pc  = pc;
      end
    end
    #1;
    if (chk) begin
      check("cycle_count", cycle_count, m_cyc);
      check("retired_count", retired_count, m_ret);
      check("pc_last", pc_last, m_pc);
      check("s_cycle_count", s_cycle_count, m_cyc[2:0]);
      check("s_retired_count", s_retired_count, m_ret[2:0]);
    end
  endtask

  initial begin
    logic [4:0]  wr;
    logic [31:0] iwr;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_cyc = 64'h0; m_ret = 64'h0; m_pc = 32'h0;
    reset = 1'b0; wb_en_in = 1'b0; wb_reg_in = 5'd0; alu_in = 32'h0;
    pc_in = 32'h0; iw_in = 32'h0; rs1_reg = 5'd0; rs2_reg = 5'd0;
    @(posedge clk);
    #1;

    // reset held 3 cycles; the first precedes any defined state
    cyc(1'b0, 1'b1, 5'd3, 32'h1111, 32'h0, 32'h13, 5'd3, 5'd4, 1'b0);
    cyc(1'b0, 1'b1, 5'd3, 32'h2222, 32'h4, 32'h13, 5'd3, 5'd3, 1'b1);
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 32'h8, 32'h0, 5'd1, 5'd2, 1'b1);
    check("rst_cycle_count", cycle_count, 64'd0);
    check("rst_retired_count", retired_count, 64'd0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b1);
    check("cycle_after_5", cycle_count, 64'd5);

    // bypass then array read of x5
    cyc(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 32'h0, 32'h0, 5'd5, 5'd5, 1'b1);
    cyc(1'b1, 1'b0, 5'd5, 32'h0, 32'h0, 32'h0, 5'd5, 5'd1, 1'b1);
    check("x5_from_array", rs1_data, 32'hDEADBEEF);

    // x0 write is dropped
    cyc(1'b1, 1'b1, 5'd0, 32'h12345678, 32'h0, 32'h0, 5'd0, 5'd0, 1'b1);
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd5, 1'b1);
    check("x0_later", rs1_data, 32'h0);

    // instruction stream: bubbles don't retire, the store does
    cyc(1'b1, 1'b1, 5'd1, 32'd5,  32'h100, 32'h00500093, 5'd1, 5'd2, 1'b1);
    cyc(1'b1, 1'b0, 5'd0, 32'd0,  32'h104, 32'h00000000, 5'd1, 5'd2, 1'b1);
    cyc(1'b1, 1'b1, 5'd2, 32'd10, 32'h108, 32'h00A00113, 5'd1, 5'd2, 1'b1);
    cyc(1'b1, 1'b0, 5'd0, 32'd0,  32'h10C, 32'h00000023, 5'd1, 5'd2, 1'b1);
    cyc(1'b1, 1'b0, 5'd0, 32'd0,  32'h110, 32'h00000000, 5'd1, 5'd2, 1'b1);
    check("stream_retired", retired_count, 64'd3);
    check("stream_pc_last", pc_last, 32'h10C);

    // reset mid-stream discards the presented write and retire
    cyc(1'b1, 1'b1, 5'd7, 32'h55, 32'h200, 32'h00000013, 5'd7, 5'd0, 1'b1);
    cyc(1'b0, 1'b1, 5'd7, 32'hAA, 32'h204, 32'h00700393, 5'd7, 5'd7, 1'b1);
    cyc(1'b1, 1'b0, 5'd7, 32'h0,  32'h208, 32'h00000000, 5'd7, 5'd7, 1'b1);
    check("x7_after_reset", rs1_data, 32'h0);
    check("retired_after_reset", retired_count, 64'd0);

    // counter wrap on the narrow instance: 8 cycles after reset wraps to 0
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b1);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 5'd0, 32'h0, 32'h300, 32'h3, 5'd0, 5'd0, 1'b1);
    check("wrap_cycle_s", s_cycle_count, 3'd0);
    check("wrap_retired_s", s_retired_count, 3'd0);
    check("cycle_no_wrap", cycle_count, 64'd8);

    // randomized traffic with occasional reset and read/write collisions
    for (int i = 0; i < 60; i++) begin
      wr  = 5'($urandom_range(0, 31));
      iwr = $urandom;
      cyc(($urandom_range(0, 15) != 0), 1'($urandom), wr, $urandom, $urandom, iwr,
          ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31)),
          ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31)), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
